mips32_pipeline: RTL and testbench
==================================

MIPS32_PIPELINE -- requirements
Module: mips32_pipeline

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, number of 32-bit words in the unified instruction/data memory.
REQ-002 SHALL have port clock, input, 1 bit; the single clock, rising-edge active.
REQ-003 SHALL have port reset_n, input, 1 bit; asynchronous, active-low reset.
REQ-004 SHALL have no other ports; benches load and inspect state through internal names Mem[0:MEM_DEPTH-1] (32b), Reg[0:31] (32b), PC (32b), halted (1b), taken_branch (1b), all hierarchically writable.

Function
REQ-005 SHALL implement a 5-stage in-order pipeline (IF, ID, EX, MEM, WB), one instruction issued per clock when not stalled.
REQ-006 SHALL decode opcode = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0] sign-extended to 32 bits.
REQ-007 SHALL support RR ops (rd <- rs op rt): ADD 0x00, SUB 0x01, AND 0x02, SLT 0x03, MUL 0x04 (low 32 bits), OR 0x05.
REQ-008 SHALL support RI ops (rt <- rs op imm): ADDI 0x0A, SUBI 0x0B, SLTI 0x0C; SLT/SLTI compare signed and write 1 or 0.
REQ-009 SHALL support LW 0x0D (rt <- Mem[rs+imm]) and SW 0x0E (Mem[rs+imm] <- rt), word-addressed, address taken modulo MEM_DEPTH.
REQ-010 SHALL support BNEQZ 0x0F / BEQZ 0x10: branch when rs != 0 / rs == 0, target = address of branch + 1 + imm, resolved in EX.
REQ-011 SHALL, on a taken branch, assert taken_branch for one cycle, load PC with target and flush the two younger instructions (IF, ID) to bubbles.
REQ-012 SHALL support HLT 0x3F: when HLT reaches WB, set halted = 1; instructions younger than HLT SHALL NOT write Reg or Mem.
REQ-013 SHALL, while halted = 1, freeze PC and perform no Reg/Mem writes until reset.
REQ-014 SHALL treat any other opcode as a NOP (no register, memory or PC side effects beyond PC+1).
REQ-015 SHALL return 0 for any read of register 0 and SHALL ignore writes to register 0.
REQ-016 SHALL forward ALU results from EX/MEM and MEM/WB to EX operands, and bypass a same-cycle WB write to ID reads; youngest source wins.
REQ-017 SHALL stall IF/ID for exactly one cycle (inserting a bubble into EX) when the instruction in ID uses the rt of an LW currently in EX.
REQ-018 SHALL forward store data (rt) for SW as in REQ-016.
REQ-019 SHALL wrap arithmetic modulo 2^32 with no overflow trap.
REQ-020 SHALL resolve branch/stall priority as: taken branch flush > load-use stall.

Reset
REQ-021 SHALL on reset_n low asynchronously clear PC, halted, taken_branch and all pipeline registers (bubbles, no pending writes).
REQ-022 SHALL NOT reset Mem or Reg contents; a bench preloads them while reset is asserted or before the first edge.
REQ-023 SHALL begin fetching at address 0 on the first rising clock edge after reset_n goes high.

Structure
REQ-024 SHALL place opcode constants and the instruction-type enumeration (RR, RI, LOAD, STORE, BRANCH, HALT) in a shared package mips32_pkg.
REQ-025 SHALL implement the ALU as one sub-module mips32_alu (operands, opcode in; 32-bit result out); all else in mips32_pipeline.

Verification
REQ-026 Reg[k] = k, Mem[120] = 85, program ADDI R1,R0,120; OR R3,R3,R3; LW R2,0(R1); OR; ADDI R2,R2,45; OR; SW R2,1(R1); HLT -> Mem[121] = 130, Mem[120] = 85, halted = 1.
REQ-027 Same program without the OR fillers -> Mem[121] = 130 (forwarding plus one load-use stall).
REQ-028 ADDI R1,R0,10; ADDI R2,R0,20; ADD R3,R1,R2; SUB R4,R2,R1; SLT R5,R1,R2; MUL R6,R1,R2; HLT -> R3 = 30, R4 = 10, R5 = 1, R6 = 200.
REQ-029 Countdown loop: ADDI R1,R0,3; SUBI R1,R1,1; BNEQZ R1,-2; HLT -> R1 = 0, taken_branch pulses twice, flushed instructions cause no writes.
REQ-030 HLT followed by ADDI R7,R0,99 -> R7 unchanged and PC frozen for 20 further cycles.
REQ-031 Assert reset_n mid-program -> PC = 0, halted = 0 immediately (asynchronously); the program reruns from address 0 after release.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared opcode constants, instruction classes and the opcode classifier
// used by the MIPS32 pipeline and its ALU.
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_SLT   = 6'h03;
  localparam logic [5:0] OP_MUL   = 6'h04;
  localparam logic [5:0] OP_OR    = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h0A;
  localparam logic [5:0] OP_SUBI  = 6'h0B;
  localparam logic [5:0] OP_SLTI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h0D;
  localparam logic [5:0] OP_SW    = 6'h0E;
  localparam logic [5:0] OP_BNEQZ = 6'h0F;
  localparam logic [5:0] OP_BEQZ  = 6'h10;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  typedef enum logic [2:0] {
    IT_RR, IT_RI, IT_LOAD, IT_STORE, IT_BRANCH, IT_HALT, IT_NOP
  } instr_type_e;

  function automatic instr_type_e decode_type(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_SLT, OP_MUL, OP_OR: return IT_RR;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return IT_RI;
      OP_LW:                                         return IT_LOAD;
      OP_SW:                                         return IT_STORE;
      OP_BNEQZ, OP_BEQZ:                             return IT_BRANCH;
      OP_HLT:                                        return IT_HALT;
      default:                                       return IT_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mips32_if.sv
// Operand/result bundle between the pipeline's EX stage and the ALU.
interface mips32_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [5:0]  op;
  logic [31:0] result;

  modport master (output a, b, op, input result);
  modport slave  (input a, b, op, output result);
endinterface

// File: rtl/mips32_alu.sv
// Combinational ALU; address arithmetic for LW/SW shares the adder.
module mips32_alu
  import mips32_pkg::*;
(
  mips32_if.slave bus
);

  always_comb begin
    bus.result = '0;
    case (bus.op)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: bus.result = bus.a + bus.b;
      OP_SUB, OP_SUBI:               bus.result = bus.a - bus.b;
      OP_AND:                        bus.result = bus.a & bus.b;
      OP_OR:                         bus.result = bus.a | bus.b;
      OP_SLT, OP_SLTI:               bus.result = {31'd0, $signed(bus.a) < $signed(bus.b)};
      OP_MUL:                        bus.result = bus.a * bus.b;
      default:                       bus.result = '0;
    endcase
  end

endmodule

// File: rtl/mips32_pipeline.sv
// Five-stage in-order MIPS32 subset with forwarding, load-use stall,
// EX-resolved branches and HLT drain. Mem/Reg are not reset.
module mips32_pipeline
  import mips32_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1024
) (
  input logic clock,
  input logic reset_n
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  logic [31:0] Mem [0:MEM_DEPTH-1];
  logic [31:0] Reg [0:31];
  logic [31:0] PC;
  logic        halted;
  logic        taken_branch;

  function automatic logic [AW-1:0] mem_index(input logic [31:0] addr);
    return AW'(addr % MEM_DEPTH);
  endfunction

  logic        if_valid;
  logic [31:0] if_ir, if_npc;

  logic        ex_valid, ex_wr;
  instr_type_e ex_type;
  logic [5:0]  ex_op;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic [31:0] ex_a, ex_b, ex_imm, ex_npc;

  logic        mem_valid, mem_wr;
  instr_type_e mem_type;
  logic [4:0]  mem_dest;
  logic [31:0] mem_alu, mem_sdata;

  logic        wb_valid, wb_wr;
  instr_type_e wb_type;
  logic [4:0]  wb_dest;
  logic [31:0] wb_val;

  logic [5:0]  id_op;
  instr_type_e id_type;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic [31:0] id_imm, id_a, id_b;
  logic        id_wr, id_uses_rs, id_uses_rt;

  always_comb begin
    id_op      = if_ir[31:26];
    id_rs      = if_ir[25:21];
    id_rt      = if_ir[20:16];
    id_imm     = {{16{if_ir[15]}}, if_ir[15:0]};
    id_type    = decode_type(id_op);
    id_dest    = (id_type == IT_RR) ? if_ir[15:11] : id_rt;
    id_wr      = (id_type inside {IT_RR, IT_RI, IT_LOAD}) && (id_dest != 5'd0);
    id_uses_rs = id_type inside {IT_RR, IT_RI, IT_LOAD, IT_STORE, IT_BRANCH};
    id_uses_rt = id_type inside {IT_RR, IT_STORE};
  end

  // Register reads see the value WB is writing this same cycle.
  assign id_a = (id_rs == 5'd0) ? '0 :
                (wb_valid && wb_wr && wb_dest == id_rs) ? wb_val : Reg[id_rs];
  assign id_b = (id_rt == 5'd0) ? '0 :
                (wb_valid && wb_wr && wb_dest == id_rt) ? wb_val : Reg[id_rt];

  logic [31:0] fwd_a, fwd_b, br_target, mem_rdata, mem_result;
  logic        br_taken, ex_halt, load_use, draining;

  // A load in EX/MEM never matches here: the load-use stall keeps its consumer out of EX.
  always_comb begin
    fwd_a = ex_a;
    if (mem_valid && mem_wr && mem_type != IT_LOAD && mem_dest == ex_rs) fwd_a = mem_alu;
    else if (wb_valid && wb_wr && wb_dest == ex_rs)                      fwd_a = wb_val;
    fwd_b = ex_b;
    if (mem_valid && mem_wr && mem_type != IT_LOAD && mem_dest == ex_rt) fwd_b = mem_alu;
    else if (wb_valid && wb_wr && wb_dest == ex_rt)                      fwd_b = wb_val;
  end

  mips32_if alu_bus ();
  mips32_alu u_alu (.bus(alu_bus.slave));

  assign alu_bus.a  = fwd_a;
  assign alu_bus.b  = (ex_type == IT_RR) ? fwd_b : ex_imm;
  assign alu_bus.op = ex_op;

  assign br_taken  = ex_valid && ex_type == IT_BRANCH && ((ex_op == OP_BEQZ) == (fwd_a == '0));
  assign br_target = ex_npc + ex_imm;
  assign ex_halt   = ex_valid && ex_type == IT_HALT;
  assign load_use  = if_valid && ex_valid && ex_type == IT_LOAD && ex_wr &&
                     ((id_uses_rs && id_rs == ex_dest) || (id_uses_rt && id_rt == ex_dest));
  assign draining  = (mem_valid && mem_type == IT_HALT) || (wb_valid && wb_type == IT_HALT);

  assign mem_rdata  = Mem[mem_index(mem_alu)];
  assign mem_result = (mem_type == IT_LOAD) ? mem_rdata : mem_alu;

  always_ff @(posedge clock) begin
    if (mem_valid && mem_type == IT_STORE && !halted) Mem[mem_index(mem_alu)] <= mem_sdata;
    if (wb_valid && wb_wr && !halted) Reg[wb_dest] <= wb_val;
  end

  // HLT in EX kills everything younger, so nothing behind it reaches MEM or WB.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      PC           <= '0;
      halted       <= 1'b0;
      taken_branch <= 1'b0;
      if_valid     <= 1'b0;
      if_ir        <= '0;
      if_npc       <= '0;
      ex_valid     <= 1'b0;
      ex_wr        <= 1'b0;
      ex_type      <= IT_NOP;
      ex_op        <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_dest      <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_imm       <= '0;
      ex_npc       <= '0;
      mem_valid    <= 1'b0;
      mem_wr       <= 1'b0;
      mem_type     <= IT_NOP;
      mem_dest     <= '0;
      mem_alu      <= '0;
      mem_sdata    <= '0;
      wb_valid     <= 1'b0;
      wb_wr        <= 1'b0;
      wb_type      <= IT_NOP;
      wb_dest      <= '0;
      wb_val       <= '0;
    end else if (!halted) begin
      taken_branch <= br_taken;
      halted       <= wb_valid && wb_type == IT_HALT;

      wb_valid  <= mem_valid;
      wb_wr     <= mem_wr;
      wb_type   <= mem_type;
      wb_dest   <= mem_dest;
      wb_val    <= mem_result;

      mem_valid <= ex_valid;
      mem_wr    <= ex_wr;
      mem_type  <= ex_type;
      mem_dest  <= ex_dest;
      mem_alu   <= alu_bus.result;
      mem_sdata <= fwd_b;

      ex_valid  <= if_valid && !(br_taken || ex_halt || load_use);
      ex_wr     <= id_wr;
      ex_type   <= id_type;
      ex_op     <= id_op;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
      ex_dest   <= id_dest;
      ex_a      <= id_a;
      ex_b      <= id_b;
      ex_imm    <= id_imm;
      ex_npc    <= if_npc;

      if (br_taken) begin
        PC       <= br_target;
        if_valid <= 1'b0;
      end else if (ex_halt || draining) begin
        if_valid <= 1'b0;
      end else if (!load_use) begin
        if_valid <= 1'b1;
        if_ir    <= Mem[mem_index(PC)];
        if_npc   <= PC + 32'd1;
        PC       <= PC + 32'd1;
      end
    end else begin
      taken_branch <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mips32_pipeline.sv
// Bench: directed and random programs run on the pipeline and on an
// instruction-at-a-time reference interpreter; final state is compared.
module tb_mips32_pipeline;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  mips32_pipeline #(.MEM_DEPTH(1024)) dut (.clock(clock), .reset_n(reset_n));

  mips32_if alu_bus ();
  mips32_alu u_alu (.bus(alu_bus));

  int n_checks = 0;
  int n_fail   = 0;
  int tb_taken = 0;
  int exp_taken;

  logic [31:0] t_mem [0:1023];
  logic [31:0] t_reg [0:31];
  logic [31:0] m_mem [0:1023];
  logic [31:0] m_reg [0:31];

  always @(negedge clock) if (dut.taken_branch) tb_taken++;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish got=timeout want=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_rr(input logic [5:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_ri(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      6'h00, 6'h0A, 6'h0D, 6'h0E: return a + b;
      6'h01, 6'h0B:               return a - b;
      6'h02:                      return a & b;
      6'h05:                      return a | b;
      6'h03, 6'h0C:               return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h04:                      return a * b;
      default:                    return 32'd0;
    endcase
  endfunction

  // Architectural interpreter: one instruction per step, no pipeline notion.
  task automatic model_run();
    logic [31:0] pc, ir, a, b, imm;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    for (int i = 0; i < 1024; i++) m_mem[i] = t_mem[i];
    for (int i = 0; i < 32; i++)   m_reg[i] = t_reg[i];
    exp_taken = 0;
    pc = 0;
    for (int step = 0; step < 20000; step++) begin
      ir  = m_mem[10'(pc % 32'd1024)];
      op  = ir[31:26];
      rs  = ir[25:21];
      rt  = ir[20:16];
      rd  = ir[15:11];
      imm = {{16{ir[15]}}, ir[15:0]};
      a   = (rs == 0) ? 32'd0 : m_reg[rs];
      b   = (rt == 0) ? 32'd0 : m_reg[rt];
      if (op == 6'h3F) break;
      if (op <= 6'h05) begin
        if (rd != 0) m_reg[rd] = alu_ref(op, a, b);
      end else if (op >= 6'h0A && op <= 6'h0C) begin
        if (rt != 0) m_reg[rt] = alu_ref(op, a, imm);
      end else if (op == 6'h0D) begin
        if (rt != 0) m_reg[rt] = m_mem[10'((a + imm) % 32'd1024)];
      end else if (op == 6'h0E) begin
        m_mem[10'((a + imm) % 32'd1024)] = b;
      end else if ((op == 6'h0F && a != 0) || (op == 6'h10 && a == 0)) begin
        exp_taken++;
        pc = pc + 1 + imm;
        continue;
      end
      pc = pc + 1;
    end
  endtask

  task automatic set_defaults();
    for (int i = 0; i < 1024; i++) t_mem[i] = 32'd0;
    for (int i = 0; i < 32; i++)   t_reg[i] = i;
  endtask

  task automatic start_program(input string name);
    reset_n = 1'b0;
    #3;
    for (int i = 0; i < 1024; i++) dut.Mem[i] = t_mem[i];
    for (int i = 0; i < 32; i++)   dut.Reg[i] = t_reg[i];
    @(negedge clock);
    check({name, "_rst_pc"}, dut.PC, 32'd0);
    check({name, "_rst_halted"}, 32'(dut.halted), 32'd0);
    check({name, "_rst_taken"}, 32'(dut.taken_branch), 32'd0);
    tb_taken = 0;
    reset_n  = 1'b1;
  endtask

  task automatic finish_and_compare(input string name);
    int c;
    int mism;
    logic [31:0] pc_h;
    model_run();
    c = 0;
    while (c < 5000 && !dut.halted) begin
      @(negedge clock);
      c++;
    end
    check({name, "_halted"}, 32'(dut.halted), 32'd1);
    pc_h = dut.PC;
    repeat (20) @(negedge clock);
    check({name, "_pc_frozen"}, dut.PC, pc_h);
    for (int r = 0; r < 32; r++)
      check($sformatf("%s_r%0d", name, r), dut.Reg[r], (r == 0) ? 32'd0 : m_reg[r]);
    mism = 0;
    for (int i = 0; i < 1024; i++) if (dut.Mem[i] !== m_mem[i]) mism++;
    check({name, "_mem_bad_words"}, 32'(mism), 32'd0);
    check({name, "_taken_pulses"}, 32'(tb_taken), 32'(exp_taken));
  endtask

  task automatic gen_random(input int n);
    int r, lim;
    logic [5:0] op;
    set_defaults();
    for (int i = 1; i < 8; i++) t_reg[i] = $urandom;
    t_reg[8] = 32'd512;
    for (int i = 512; i < 528; i++) t_mem[i] = $urandom;
    for (int pc = 0; pc < n; pc++) begin
      r = $urandom_range(0, 10);
      if (r <= 4) begin
        op = 6'($urandom_range(0, 5));
        t_mem[pc] = enc_rr(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 8)),
                           5'($urandom_range(0, 8)));
      end else if (r <= 6) begin
        op = 6'(10 + $urandom_range(0, 2));
        t_mem[pc] = enc_ri(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 8)),
                           16'($urandom_range(0, 65535)));
      end else if (r == 7) begin
        t_mem[pc] = enc_ri(6'h0D, 5'($urandom_range(0, 7)), 5'd8, 16'($urandom_range(0, 15)));
      end else if (r == 8) begin
        t_mem[pc] = enc_ri(6'h0E, 5'($urandom_range(0, 8)), 5'd8, 16'($urandom_range(0, 15)));
      end else if (r == 9) begin
        lim = (n - 1 - pc < 3) ? n - 1 - pc : 3;
        op  = ($urandom_range(0, 1) == 0) ? 6'h0F : 6'h10;
        t_mem[pc] = enc_ri(op, 5'd0, 5'($urandom_range(0, 8)), 16'($urandom_range(0, lim)));
      end else begin
        t_mem[pc] = {6'h20, 26'($urandom)};
      end
    end
    t_mem[n]     = 32'hFC00_0000;
    t_mem[n + 1] = enc_ri(6'h0A, 5'd7, 5'd0, 16'd99);
  endtask

  initial begin
    logic [5:0]  aop;
    logic [31:0] aa, ab;
    logic [5:0]  ops [0:10];
    ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E};

    // Standalone ALU through its interface.
    for (int k = 0; k < 16; k++) begin
      aop = ops[$urandom_range(0, 10)];
      aa  = (k < 4) ? 32'hFFFF_FFF0 + 32'(k) : $urandom;
      ab  = $urandom;
      alu_bus.a  = aa;
      alu_bus.b  = ab;
      alu_bus.op = aop;
      #1;
      check($sformatf("alu_op%02h", aop), alu_bus.result, alu_ref(aop, aa, ab));
    end

    // Load-use with filler instructions.
    set_defaults();
    t_mem[120] = 32'd85;
    t_mem[0] = enc_ri(6'h0A, 1, 0, 16'd120);
    t_mem[1] = enc_rr(6'h05, 3, 3, 3);
    t_mem[2] = enc_ri(6'h0D, 2, 1, 16'd0);
    t_mem[3] = enc_rr(6'h05, 3, 3, 3);
    t_mem[4] = enc_ri(6'h0A, 2, 2, 16'd45);
    t_mem[5] = enc_rr(6'h05, 3, 3, 3);
    t_mem[6] = enc_ri(6'h0E, 2, 1, 16'd1);
    t_mem[7] = 32'hFC00_0000;
    start_program("fill");
    finish_and_compare("fill");
    check("fill_m121", dut.Mem[121], 32'd130);
    check("fill_m120", dut.Mem[120], 32'd85);

    // Same program back-to-back: forwarding plus one load-use stall.
    set_defaults();
    t_mem[120] = 32'd85;
    t_mem[0] = enc_ri(6'h0A, 1, 0, 16'd120);
    t_mem[1] = enc_ri(6'h0D, 2, 1, 16'd0);
    t_mem[2] = enc_ri(6'h0A, 2, 2, 16'd45);
    t_mem[3] = enc_ri(6'h0E, 2, 1, 16'd1);
    t_mem[4] = 32'hFC00_0000;
    start_program("tight");
    finish_and_compare("tight");
    check("tight_m121", dut.Mem[121], 32'd130);

    // Arithmetic mix.
    set_defaults();
    t_mem[0] = enc_ri(6'h0A, 1, 0, 16'd10);
    t_mem[1] = enc_ri(6'h0A, 2, 0, 16'd20);
    t_mem[2] = enc_rr(6'h00, 3, 1, 2);
    t_mem[3] = enc_rr(6'h01, 4, 2, 1);
    t_mem[4] = enc_rr(6'h03, 5, 1, 2);
    t_mem[5] = enc_rr(6'h04, 6, 1, 2);
    t_mem[6] = 32'hFC00_0000;
    start_program("arith");
    finish_and_compare("arith");
    check("arith_r3", dut.Reg[3], 32'd30);
    check("arith_r4", dut.Reg[4], 32'd10);
    check("arith_r5", dut.Reg[5], 32'd1);
    check("arith_r6", dut.Reg[6], 32'd200);

    // Countdown loop; R9 increment sits in the flush shadow of the branch.
    set_defaults();
    t_mem[0] = enc_ri(6'h0A, 1, 0, 16'd3);
    t_mem[1] = enc_ri(6'h0B, 1, 1, 16'd1);
    t_mem[2] = enc_ri(6'h0F, 0, 1, 16'hFFFE);
    t_mem[3] = enc_ri(6'h0A, 9, 9, 16'd1);
    t_mem[4] = 32'hFC00_0000;
    start_program("loop");
    finish_and_compare("loop");
    check("loop_r1", dut.Reg[1], 32'd0);
    check("loop_r9", dut.Reg[9], 32'd10);
    check("loop_pulses", 32'(tb_taken), 32'd2);

    // Nothing behind HLT commits.
    set_defaults();
    t_mem[0] = 32'hFC00_0000;
    t_mem[1] = enc_ri(6'h0A, 7, 0, 16'd99);
    start_program("hlt");
    finish_and_compare("hlt");
    check("hlt_r7", dut.Reg[7], 32'd7);

    for (int p = 0; p < 6; p++) begin
      gen_random(24);
      start_program($sformatf("rnd%0d", p));
      finish_and_compare($sformatf("rnd%0d", p));
    end

    // Asynchronous reset mid-program, then rerun from address 0.
    set_defaults();
    t_mem[0] = enc_ri(6'h0A, 1, 0, 16'd40);
    t_mem[1] = enc_ri(6'h0B, 1, 1, 16'd1);
    t_mem[2] = enc_ri(6'h0F, 0, 1, 16'hFFFE);
    t_mem[3] = enc_ri(6'h0A, 9, 9, 16'd1);
    t_mem[4] = 32'hFC00_0000;
    start_program("midrst");
    repeat (25) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_pc", dut.PC, 32'd0);
    check("midrst_halted", 32'(dut.halted), 32'd0);
    check("midrst_taken", 32'(dut.taken_branch), 32'd0);
    @(negedge clock);
    tb_taken = 0;
    reset_n  = 1'b1;
    finish_and_compare("rerun");
    check("rerun_r1", dut.Reg[1], 32'd0);
    check("rerun_pulses", 32'(tb_taken), 32'd39);

    #2 reset_n = 1'b0;
    #1;
    check("hltrst_halted", 32'(dut.halted), 32'd0);
    check("hltrst_pc", dut.PC, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
